// File: rtl/decimal_countdown_timer.sv
// Two-digit BCD countdown timer with a prescaled decrement tick.
// Supports load, start, pause and resume, and signals expiry at 00.
module decimal_countdown_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] out_ones,
    output logic [3:0] out_tens,
    output logic       running,
    output logic       expired,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    state_t           state_q;
    logic [3:0]       ones_q;
    logic [3:0]       tens_q;
    logic [3:0]       ones_d;
    logic [3:0]       tens_d;
    logic [CNT_W-1:0] presc_q;
    logic             running_q;
    logic             expired_q;
    logic             done_q;
    logic             tick;
    logic             is_zero;
    logic             dec_zero;

    function automatic logic [3:0] clamp9(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    assign tick    = (state_q == RUN) && (presc_q == TERM);
    assign is_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    // Decrement with borrow; saturates at 00 so digits never wrap.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
        end else if (tens_q != 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
        end
        dec_zero = (tens_d == 4'd0) && (ones_d == 4'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (load) begin
            state_q   <= IDLE;
            ones_q    <= clamp9(load_ones);
            tens_q    <= clamp9(load_tens);
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    presc_q <= '0;
                    if (start && is_zero) begin
                        state_q   <= EXPIRED;
                        expired_q <= 1'b1;
                        done_q    <= 1'b1;
                    end else if (start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc_q <= '0;
                        ones_q  <= ones_d;
                        tens_q  <= tens_d;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                    // Expiry on a tick outranks a coincident pause.
                    if (tick && dec_zero) begin
                        state_q   <= EXPIRED;
                        running_q <= 1'b0;
                        expired_q <= 1'b1;
                        done_q    <= 1'b1;
                    end else if (pause) begin
                        state_q   <= PAUSED;
                        running_q <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                EXPIRED: begin
                    presc_q <= '0;
                    ones_q  <= 4'd0;
                    tens_q  <= 4'd0;
                end
                default: begin
                    state_q   <= IDLE;
                    presc_q   <= '0;
                    running_q <= 1'b0;
                    expired_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_ones = ones_q;
    assign out_tens = tens_q;
    assign running  = running_q;
    assign expired  = expired_q;
    assign done     = done_q;

endmodule

// File: tb/tb_decimal_countdown_timer.sv
// Scoreboard bench for decimal_countdown_timer with TICK_DIV=4.
// Stimulus queues cycle-tagged expectations; a negedge monitor checks them.
module tb_decimal_countdown_timer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] out_ones;
    logic [3:0] out_tens;
    logic       running;
    logic       expired;
    logic       done;

    decimal_countdown_timer #(
        .TICK_DIV(4),
        .CNT_W   (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_tens(load_tens),
        .load_ones(load_ones),
        .start    (start),
        .pause    (pause),
        .out_ones (out_ones),
        .out_tens (out_tens),
        .running  (running),
        .expired  (expired),
        .done     (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        string      nm;
        logic [3:0] t;
        logic [3:0] o;
        logic       r;
        logic       e;
        logic       d;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t x;
            x = sb.pop_front();
            checks++;
            if (x.cyc < cyc) begin
                failures++;
                $display("FAIL %s: missed check cycle %0d (now %0d)", x.nm, x.cyc, cyc);
            end else if (out_tens !== x.t || out_ones !== x.o || running !== x.r ||
                         expired !== x.e || done !== x.d) begin
                failures++;
                $display("FAIL %s: got %0d%0d r=%b e=%b d=%b want %0d%0d r=%b e=%b d=%b",
                         x.nm, out_tens, out_ones, running, expired, done,
                         x.t, x.o, x.r, x.e, x.d);
            end
        end
    end

    // Expect outputs after the d-th upcoming rising edge.
    task automatic expect_at(input int d, input string nm, input logic [3:0] t,
                             input logic [3:0] o, input logic r, input logic e,
                             input logic dn);
        exp_t x;
        x.cyc = cyc + d;
        x.nm  = nm;
        x.t   = t;
        x.o   = o;
        x.r   = r;
        x.e   = e;
        x.d   = dn;
        sb.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load      = 1'b1;
        load_tens = t;
        load_ones = o;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        step(1);
        // 1: reset, load 12, count with borrow
        reset = 1'b1;
        expect_at(1, "reset", 0, 0, 0, 0, 0);
        step(1);
        reset = 1'b0;
        expect_at(1, "load12", 1, 2, 0, 0, 0);
        do_load(4'd1, 4'd2);
        expect_at(1, "start12", 1, 2, 1, 0, 0);
        do_start();
        expect_at(3, "hold12", 1, 2, 1, 0, 0);
        expect_at(4, "dec11", 1, 1, 1, 0, 0);
        expect_at(8, "dec10", 1, 0, 1, 0, 0);
        expect_at(12, "borrow09", 0, 9, 1, 0, 0);
        expect_at(16, "dec08", 0, 8, 1, 0, 0);
        step(16);

        // 2: load 02, expire, later starts ignored
        expect_at(1, "load02", 0, 2, 0, 0, 0);
        do_load(4'd0, 4'd2);
        do_start();
        expect_at(4, "dec01", 0, 1, 1, 0, 0);
        expect_at(7, "hold01", 0, 1, 1, 0, 0);
        expect_at(8, "expire", 0, 0, 0, 1, 1);
        expect_at(9, "donepulse", 0, 0, 0, 1, 0);
        step(9);
        start = 1'b1;
        pause = 1'b1;
        expect_at(1, "expstart", 0, 0, 0, 1, 0);
        step(1);
        start = 1'b0;
        pause = 1'b0;

        // 3: pause and resume with held prescaler
        do_load(4'd3, 4'd0);
        do_start();
        step(2);
        pause = 1'b1;
        expect_at(1, "pause30", 3, 0, 0, 0, 0);
        expect_at(10, "paused30", 3, 0, 0, 0, 0);
        step(10);
        pause = 1'b0;
        start = 1'b1;
        expect_at(1, "resume30", 3, 0, 1, 0, 0);
        step(1);
        start = 1'b0;
        expect_at(1, "dec29", 2, 9, 1, 0, 0);
        step(1);

        // 4: pause coinciding with final tick
        do_load(4'd0, 4'd1);
        do_start();
        step(3);
        pause = 1'b1;
        expect_at(1, "pauseexp", 0, 0, 0, 1, 1);
        step(1);
        pause = 1'b0;
        expect_at(1, "pauseexp2", 0, 0, 0, 1, 0);
        step(1);

        // 5: clamp and start from 00
        expect_at(1, "clamp99", 9, 9, 0, 0, 0);
        do_load(4'hF, 4'hC);
        expect_at(1, "load00", 0, 0, 0, 0, 0);
        do_load(4'd0, 4'd0);
        expect_at(1, "start00", 0, 0, 0, 1, 1);
        do_start();
        expect_at(1, "start00b", 0, 0, 0, 1, 0);
        step(1);

        // load outranks start
        load_tens = 4'd0;
        load_ones = 4'd5;
        load  = 1'b1;
        start = 1'b1;
        expect_at(1, "ldprio", 0, 5, 0, 0, 0);
        step(1);
        load  = 1'b0;
        start = 1'b0;

        // 6: reset mid-count, then start from 00
        do_load(4'd0, 4'd7);
        do_start();
        step(2);
        reset = 1'b1;
        expect_at(1, "midreset", 0, 0, 0, 0, 0);
        step(1);
        reset = 1'b0;
        expect_at(1, "rststart", 0, 0, 0, 1, 1);
        do_start();
        step(1);

        begin
            int budget = 20;
            while (sb.size() > 0 && budget > 0) begin
                step(1);
                budget--;
            end
            if (sb.size() > 0) begin
                failures++;
                checks++;
                $display("FAIL drain: %0d checks pending, want 0", sb.size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
